mul_share_ctl: RTL
==================

# mul_share_ctl

Round-robin controller sharing one shift-and-add multiplier among N_REQ requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues one at a time to the multiplier, and returns each 2·WIDTH-bit product tagged with the requester index. An optional constant-time mode releases every response at a fixed latency, hiding the multiplier's operand-dependent early termination from requesters.

## Interface
- N_REQ, 4: number of requesters (≥2).
- WIDTH, 32: operand width; product is 2·WIDTH.
- CT_LAT, WIDTH+3: fixed issue-to-response latency in constant-time mode.
- FLUSH_CYCLES, WIDTH+3: post-reset drain length.
- in_clk  in  1  sole clock, rising edge.
- in_rst  in  1  synchronous, active-high reset.
- ct_mode  in  1  constant-time enable, sampled at grant.
- req_valid  in  N_REQ  per-requester request.
- req_a, req_b  in  N_REQ·WIDTH each  packed operands; slice i belongs to requester i.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- resp_valid  out  1  one-cycle response pulse.
- resp_id  out  clog2(N_REQ)  owner of resp_o.
- resp_o  out  2·WIDTH  product.
- err  out  1  sticky multiplier-timeout flag.
- ctl_busy  out  1  high whenever the FSM is not in IDLE.
- mul_in_valid  out  1  start pulse to the multiplier.
- mul_a, mul_b  out  WIDTH  operands to the multiplier.
- mul_o  in  2·WIDTH  multiplier result.
- mul_out_valid  in  1  multiplier finish flag.

## Operation
- Reset values:
  - State = FLUSH; ctl_busy = 1.
  - req_ready, resp_valid, resp_id, resp_o, mul_in_valid, mul_a, mul_b and err = 0.
  - RR pointer = N_REQ−1, so requester 0 has first priority.
- The multiplier has no reset and accepts a start only when idle. Its latency from start is L ∈ [2, WIDTH+2] cycles: 2 if a or b is 0, up to WIDTH+2 when b[WIDTH−1] = 1. mul_out_valid can stay high for up to 2 cycles.
- **FLUSH:**
  - Count FLUSH_CYCLES cycles, ignoring mul_out_valid, so that any operation in flight at reset drains.
  - Then go to IDLE.
- **IDLE:**
  - Arbitration runs only when mul_out_valid = 0.
  - Search starts at pointer+1 (mod N_REQ); the first i with req_valid[i] = 1 wins.
  - req_ready[i] is asserted combinationally in the same cycle.
  - On the transfer: latch req_a[i], req_b[i], id = i and ct = ct_mode; set pointer = i; go to ISSUE.
  - All req_ready bits are 0 in every state other than IDLE.
- **ISSUE (1 cycle):**
  - mul_in_valid = 1, with mul_a/mul_b driven from the latches.
  - The latency counter is cleared to 0 this cycle.
  - Go to WAIT.
  - mul_a/mul_b hold their values until the next ISSUE.
- **WAIT:**
  - The counter increments every cycle.
  - On the first cycle with mul_out_valid = 1, capture mul_o into resp_o, then go to HOLD if ct is set, otherwise to RESP.
  - If the counter reaches WIDTH+3 with no mul_out_valid: set err, set resp_o = 0, go to RESP.
- **HOLD:** Wait until counter = CT_LAT−1, then go to RESP.
- **RESP (1 cycle):**
  - resp_valid = 1, with resp_id = id and resp_o valid.
  - Go to IDLE.
  - resp_o and resp_id hold their values after the pulse.
- Products are unsigned, full 2·WIDTH bits, taken verbatim from mul_o.
- err clears only on in_rst.
- Reset mid-operation: any in-flight request is dropped with no response, and the controller restarts in FLUSH. Requesters must re-present dropped requests.
- Requesters must hold req_valid and operands stable until their grant. The controller never grants a requester whose req_valid is low.

## Timing
- Grant cycle G, issue cycle T = G+1.
- Normal mode: resp_valid at T+L+1, i.e. between G+4 and G+WIDTH+4.
- ct mode: resp_valid at exactly T+CT_LAT, independent of operands.
- The next grant is no earlier than the cycle after RESP, and only once mul_out_valid = 0. Throughput is at most one operation per L+3 cycles.
- Simultaneous requests: one grant per IDLE visit in RR order. With all requesters valid, grants rotate 0,1,2,3,0,…
- After reset deasserts, the first grant is no earlier than FLUSH_CYCLES cycles later.

## Test plan
- **Reset drain:** assert in_rst for 1 cycle while the multiplier is mid-operation (b=0xFFFFFFFF) → no resp_valid during FLUSH; the first grant occurs ≥35 cycles later.
- **Single request, normal mode:** requester 2 sends a=3, b=5 → resp_o=15, resp_id=2, resp_valid exactly T+L+1.
- **Zero operand, normal mode:** a=0, b=0x1234 → resp_o=0 at T+3. **Same operand in ct mode:** resp at T+35, identical cycle to a=0xFFFFFFFF, b=0xFFFFFFFF (resp_o=0xFFFFFFFE00000001).
- **Fairness:** all four requesters held valid → grant order 0,1,2,3,0; each requester receives its own product and id.
- **Timeout:** stub multiplier never asserts mul_out_valid → err=1 and resp_valid with resp_o=0 at T+WIDTH+4; err stays 1 until in_rst.
- **Reset during HOLD:** assert in_rst while in HOLD → no resp_valid for that request; req_ready=0 throughout FLUSH; the same requester is regranted after FLUSH.

Source files
------------

// File: rtl/mul_share_ctl.sv
// mul_share_ctl
// Shares one shift-and-add multiplier among N_REQ requesters. Each
// requester presents an operand pair over a valid/ready handshake. The
// controller picks one requester at a time in round-robin order, starts the
// multiplier, and returns the 2*WIDTH-bit product tagged with the requester
// index. In constant-time mode the response is held back so that it always
// appears CT_LAT cycles after issue, whatever the operands.
//
// Ports
//   in_clk, in_rst    clock (rising edge) and synchronous active-high reset
//   ct_mode           constant-time enable, sampled at grant
//   req_valid         per-requester request
//   req_a, req_b      packed operands, slice i belongs to requester i
//   req_ready         one-hot grant (combinational, IDLE only)
//   resp_valid        one-cycle response pulse
//   resp_id, resp_o   owner index and product, held after the pulse
//   err               sticky multiplier-timeout flag
//   ctl_busy          high whenever the controller is not idle
//   mul_in_valid      start pulse to the multiplier
//   mul_a, mul_b      multiplier operands
//   mul_o             multiplier result
//   mul_out_valid     multiplier finish flag
module mul_share_ctl #(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 32,
    parameter int CT_LAT       = WIDTH + 3,
    parameter int FLUSH_CYCLES = WIDTH + 3
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         ct_mode,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*WIDTH-1:0]       req_a,
    input  logic [N_REQ*WIDTH-1:0]       req_b,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         resp_valid,
    output logic [$clog2(N_REQ)-1:0]     resp_id,
    output logic [2*WIDTH-1:0]           resp_o,
    output logic                         err,
    output logic                         ctl_busy,
    output logic                         mul_in_valid,
    output logic [WIDTH-1:0]             mul_a,
    output logic [WIDTH-1:0]             mul_b,
    input  logic [2*WIDTH-1:0]           mul_o,
    input  logic                         mul_out_valid
);
    localparam int ID_W    = $clog2(N_REQ);
    localparam int TMO     = WIDTH + 3;
    localparam int MAX_A   = (TMO > CT_LAT) ? TMO : CT_LAT;
    localparam int CNT_MAX = (MAX_A > FLUSH_CYCLES) ? MAX_A : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               ct_q, ct_d;
    logic [2*WIDTH-1:0] resp_o_q, resp_o_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting one past the last winner.
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    int              cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr_q) + k) % N_REQ;
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // A lingering finish flag from the previous operation blocks arbitration,
    // so a new start is never offered to a multiplier that is not yet idle.
    logic arb_en;
    assign arb_en = (state_q == S_IDLE) && !mul_out_valid && grant_found;

    always_comb begin
        req_ready = '0;
        if (arb_en) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        ct_d      = ct_q;
        resp_o_d  = resp_o_q;
        resp_id_d = resp_id_q;
        err_d     = err_q;
        case (state_q)
            S_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (arb_en) begin
                    a_d     = a_arr[grant_idx];
                    b_d     = b_arr[grant_idx];
                    id_d    = grant_idx;
                    ct_d    = ct_mode;
                    ptr_d   = grant_idx;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Counter equals the number of cycles elapsed since issue.
                cnt_d   = CNT_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_out_valid) begin
                    resp_o_d  = mul_o;
                    resp_id_d = id_q;
                    // At the slowest latency the hold point is already
                    // reached, so go straight to RESP to keep the fixed latency.
                    if (ct_q && (cnt_q < CNT_W'(CT_LAT - 1))) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (cnt_q >= CNT_W'(TMO)) begin
                    err_d     = 1'b1;
                    resp_o_d  = '0;
                    resp_id_d = id_q;
                    state_d   = S_RESP;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q >= CNT_W'(CT_LAT - 1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q   <= S_FLUSH;
            cnt_q     <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            ct_q      <= 1'b0;
            resp_o_q  <= '0;
            resp_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            ct_q      <= ct_d;
            resp_o_q  <= resp_o_d;
            resp_id_q <= resp_id_d;
            err_q     <= err_d;
        end
    end

    assign resp_valid   = (state_q == S_RESP);
    assign resp_id      = resp_id_q;
    assign resp_o       = resp_o_q;
    assign err          = err_q;
    assign ctl_busy     = (state_q != S_IDLE);
    assign mul_in_valid = (state_q == S_ISSUE);
    assign mul_a        = a_q;
    assign mul_b        = b_q;
endmodule
